// File: rtl/jtag_dr_tdo.sv
// jtag_dr_tdo: TDO-side ER1/ER2 mailbox transmitter for JTAGG, oversampling JTCK in the clk domain.
// Define JTAG_DR_TDO_STATUS_EN to prepend a valid flag (bit 0) to each captured word.
module jtag_dr_tdo #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             jtck,
  input  logic             jshift,
  input  logic             jce1,
  input  logic             jce2,
  input  logic             jrstn,
  input  logic [WIDTH-1:0] tx_data0,
  input  logic             tx_load0,
  output logic             tx_full0,
  output logic             tx_taken0,
  input  logic [WIDTH-1:0] tx_data1,
  input  logic             tx_load1,
  output logic             tx_full1,
  output logic             tx_taken1,
  output logic             jtdo1,
  output logic             jtdo2
);
`ifdef JTAG_DR_TDO_STATUS_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int N = SYNC_STAGES;
  logic [N-1:0]     r_tck, r_sh, r_ce1, r_ce2;
  logic             w_rise, w_fall, w_shift;
  logic [1:0]       w_ce, w_load, w_cap, w_shf, w_full, w_taken, w_tdo;
  logic [WIDTH-1:0] w_data [2];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tck <= '0;
      r_sh  <= '0;
      r_ce1 <= '0;
      r_ce2 <= '0;
    end else begin
      r_tck <= {r_tck[N-2:0], jtck};
      r_sh  <= {r_sh[N-2:0], jshift};
      r_ce1 <= {r_ce1[N-2:0], jce1};
      r_ce2 <= {r_ce2[N-2:0], jce2};
    end
  end
  assign w_rise    = ~r_tck[N-1] & r_tck[N-2];
  assign w_fall    = r_tck[N-1] & ~r_tck[N-2];
  assign w_shift   = r_sh[N-2];
  // ER1 wins if both enables are ever seen together
  assign w_ce      = {r_ce2[N-2] & ~r_ce1[N-2], r_ce1[N-2]};
  assign w_load    = {tx_load1, tx_load0};
  assign w_data[0] = tx_data0;
  assign w_data[1] = tx_data1;
  assign w_cap     = w_ce & {2{w_rise & ~w_shift & jrstn}};
  assign w_shf     = w_ce & {2{w_rise & w_shift & jrstn}};
  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [WIDTH-1:0] r_mb;
    logic             r_full, r_taken, r_tdo;
    logic [SW-1:0]    r_shreg, w_cap_word;
`ifdef JTAG_DR_TDO_STATUS_EN
    assign w_cap_word = {r_mb, 1'b1};
`else
    assign w_cap_word = r_mb;
`endif
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_mb    <= '0;
        r_full  <= 1'b0;
        r_taken <= 1'b0;
        r_shreg <= '0;
        r_tdo   <= 1'b0;
      end else begin
        r_taken <= w_cap[k] & r_full;
        if (w_load[k]) begin
          r_mb   <= w_data[k];
          r_full <= 1'b1;
        end else if (w_cap[k]) r_full <= 1'b0;
        if (!jrstn) begin
          r_shreg <= '0;
          r_tdo   <= 1'b0;
        end else begin
          if (w_cap[k]) r_shreg <= r_full ? w_cap_word : '0;
          else if (w_shf[k]) r_shreg <= {1'b0, r_shreg[SW-1:1]};
          if (w_fall && w_ce[k]) r_tdo <= r_shreg[0];
        end
      end
    end
    assign w_full[k]  = r_full;
    assign w_taken[k] = r_taken;
    assign w_tdo[k]   = r_tdo;
  end
  assign tx_full0  = w_full[0];
  assign tx_full1  = w_full[1];
  assign tx_taken0 = w_taken[0];
  assign tx_taken1 = w_taken[1];
  assign jtdo1     = w_tdo[0];
  assign jtdo2     = w_tdo[1];
endmodule

// File: tb/tb_jtag_dr_tdo.sv
// tb_jtag_dr_tdo: randomized self-checking bench for jtag_dr_tdo against a mailbox-level model.
module tb_jtag_dr_tdo;
  localparam int W    = 32;
  localparam int N    = 4;
  localparam int HALF = 24;
`ifdef JTAG_DR_TDO_STATUS_EN
  localparam int SW = W + 1;
`else
  localparam int SW = W;
`endif
  logic clk = 0, rstn = 0, jtck = 0, jshift = 0, jce1 = 0, jce2 = 0, jrstn = 1;
  logic [W-1:0] tx_data0 = '0, tx_data1 = '0;
  logic tx_load0 = 0, tx_load1 = 0;
  logic tx_full0, tx_taken0, tx_full1, tx_taken1, jtdo1, jtdo2;
  int total = 0, bad = 0, tk0 = 0, tk1 = 0;
  bit seen2 = 0;
  logic [W-1:0] m_mb [2];
  bit m_full [2];

  jtag_dr_tdo #(.WIDTH(W), .SYNC_STAGES(N)) dut (
    .clk(clk), .rstn(rstn), .jtck(jtck), .jshift(jshift), .jce1(jce1), .jce2(jce2),
    .jrstn(jrstn), .tx_data0(tx_data0), .tx_load0(tx_load0), .tx_full0(tx_full0),
    .tx_taken0(tx_taken0), .tx_data1(tx_data1), .tx_load1(tx_load1), .tx_full1(tx_full1),
    .tx_taken1(tx_taken1), .jtdo1(jtdo1), .jtdo2(jtdo2)
  );

  always #10 clk = ~clk;
  always @(posedge clk) begin
    if (tx_taken0) tk0++;
    if (tx_taken1) tk1++;
    if (jtdo2) seen2 = 1;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] expv(input int ch);
`ifdef JTAG_DR_TDO_STATUS_EN
    return m_full[ch] ? 64'(m_mb[ch]) * 2 + 1 : 64'd0;
`else
    return m_full[ch] ? 64'(m_mb[ch]) : 64'd0;
`endif
  endfunction

  task automatic load(input int ch, input logic [W-1:0] d);
    @(posedge clk); #1;
    if (ch == 0) begin tx_data0 = d; tx_load0 = 1; end
    else begin tx_data1 = d; tx_load1 = 1; end
    @(posedge clk); #1;
    tx_load0 = 0; tx_load1 = 0;
    m_mb[ch] = d; m_full[ch] = 1;
  endtask

  // one TCK period; tdo sampled just before the rising edge, optional load aligned to capture
  task automatic jcyc(input bit c1, input bit c2, input bit sh, input bit ld, output bit t1, output bit t2);
    jce1 = c1; jce2 = c2; jshift = sh;
    repeat (HALF / 2) @(posedge clk);
    #1; t1 = jtdo1; t2 = jtdo2; jtck = 1;
    for (int i = 0; i < HALF; i++) begin
      @(posedge clk); #1;
      tx_load0 = ld && i == N - 2;
    end
    jtck = 0;
    repeat (HALF / 2) @(posedge clk);
    #1;
  endtask

  task automatic read(input int ch, input int n, output logic [63:0] v);
    bit a, b;
    v = '0;
    jcyc(ch == 0, ch == 1, 0, 0, a, b);
    for (int i = 0; i < n; i++) begin
      jcyc(ch == 0, ch == 1, 1, 0, a, b);
      v[i] = ch == 0 ? a : b;
    end
    jcyc(0, 0, 0, 0, a, b);
  endtask

  task automatic test_reset();
    bit a, b;
    int t1;
    total++;
    if ({jtdo1, jtdo2, tx_full0, tx_full1, tx_taken0, tx_taken1} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs: got %b required 000000", {jtdo1, jtdo2, tx_full0, tx_full1, tx_taken0, tx_taken1});
    end
    repeat (3) @(posedge clk); #1; rstn = 1;
    load(0, 32'hFFFF_FFFF);
    load(1, 32'h1234_5678);
    jcyc(1, 0, 0, 0, a, b);
    for (int i = 0; i < 3; i++) jcyc(1, 0, 1, 0, a, b);
    total++;
    if (jtdo1 !== 1'b1) begin bad++; $display("FAIL reset_preshift_tdo: got %b required 1", jtdo1); end
    t1 = tk1;
    rstn = 0; #1;
    jce1 = 0; jshift = 0;
    total++;
    if (jtdo1 !== 1'b0) begin bad++; $display("FAIL reset_mid_tdo: got %b required 0", jtdo1); end
    total++;
    if ({tx_full0, tx_full1} !== 2'b00) begin bad++; $display("FAIL reset_mid_full: got %b required 00", {tx_full0, tx_full1}); end
    m_full[0] = 0; m_full[1] = 0;
    repeat (4) @(posedge clk); #1; rstn = 1;
    repeat (4) @(posedge clk); #1;
    total++;
    if (tk1 !== t1) begin bad++; $display("FAIL reset_taken1: got %0d required %0d", tk1, t1); end
  endtask

  task automatic test_basic();
    logic [63:0] v, e;
    int t0;
    load(0, 32'hDEAD_BEEF);
    total++;
    if (tx_full0 !== 1'b1) begin bad++; $display("FAIL basic_full_set: got %b required 1", tx_full0); end
    e = expv(0); m_full[0] = 0;
    t0 = tk0; seen2 = 0;
    read(0, SW, v);
    total++;
    if (v !== e) begin bad++; $display("FAIL basic_read: got %h required %h", v, e); end
    total++;
    if (tk0 - t0 !== 1) begin bad++; $display("FAIL basic_taken: got %0d pulse cycles required 1", tk0 - t0); end
    total++;
    if (tx_full0 !== 1'b0) begin bad++; $display("FAIL basic_full_clr: got %b required 0", tx_full0); end
    total++;
    if (seen2 !== 1'b0) begin bad++; $display("FAIL basic_jtdo2_quiet: got %b required 0", seen2); end
  endtask

  task automatic test_empty();
    logic [63:0] v;
    int t1;
    t1 = tk1;
    read(1, SW, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL empty_read: got %h required 0", v); end
    total++;
    if (tk1 !== t1) begin bad++; $display("FAIL empty_taken: got %0d required %0d", tk1, t1); end
  endtask

  task automatic test_collision();
    logic [63:0] v, e;
    bit a, b;
    int t0;
    load(0, 32'h0000_AAAA);
    e = expv(0);
    t0 = tk0;
    tx_data0 = 32'h1234_5678;
    v = '0;
    jcyc(1, 0, 0, 1, a, b);
    for (int i = 0; i < SW; i++) begin
      jcyc(1, 0, 1, 0, a, b);
      v[i] = a;
    end
    jcyc(0, 0, 0, 0, a, b);
    m_mb[0] = 32'h1234_5678; m_full[0] = 1;
    total++;
    if (v !== e) begin bad++; $display("FAIL coll_read: got %h required %h", v, e); end
    total++;
    if (tk0 - t0 !== 1) begin bad++; $display("FAIL coll_taken: got %0d required 1", tk0 - t0); end
    total++;
    if (tx_full0 !== 1'b1) begin bad++; $display("FAIL coll_full: got %b required 1", tx_full0); end
    e = expv(0); m_full[0] = 0;
    read(0, SW, v);
    total++;
    if (v !== e) begin bad++; $display("FAIL coll_reread: got %h required %h", v, e); end
  endtask

  task automatic test_tap_reset();
    logic [63:0] v, e;
    bit a, b;
    load(0, 32'hCAFE_F00D);
    e = expv(0); m_full[0] = 0;
    v = '0;
    jcyc(1, 0, 0, 0, a, b);
    for (int i = 0; i < 10; i++) begin
      jcyc(1, 0, 1, 0, a, b);
      v[i] = a;
    end
    total++;
    if (v[9:0] !== e[9:0]) begin bad++; $display("FAIL tap_first10: got %h required %h", v[9:0], e[9:0]); end
    jrstn = 0;
    repeat (5) @(posedge clk); #1;
    total++;
    if (jtdo1 !== 1'b0) begin bad++; $display("FAIL tap_tdo: got %b required 0", jtdo1); end
    total++;
    if (tx_full0 !== 1'b0) begin bad++; $display("FAIL tap_full: got %b required 0", tx_full0); end
    jrstn = 1;
    v = '0;
    for (int i = 10; i < SW; i++) begin
      jcyc(1, 0, 1, 0, a, b);
      v[i] = a;
    end
    jcyc(0, 0, 0, 0, a, b);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL tap_cleared: got %h required 0", v); end
    load(0, 32'h1357_9BDF);
    e = expv(0); m_full[0] = 0;
    read(0, SW, v);
    total++;
    if (v !== e) begin bad++; $display("FAIL tap_newword: got %h required %h", v, e); end
  endtask

  task automatic test_random();
    logic [63:0] v, e;
    int ch, t, k;
    for (int it = 0; it < 6; it++) begin
      ch = int'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 3));
      for (int j = 0; j < k; j++) load(ch, $urandom);
      e = expv(ch);
      k = m_full[ch] ? 1 : 0;
      m_full[ch] = 0;
      t = ch == 0 ? tk0 : tk1;
      read(ch, SW, v);
      total++;
      if (v !== e) begin bad++; $display("FAIL rand_read[%0d] ch%0d: got %h required %h", it, ch, v, e); end
      total++;
      if ((ch == 0 ? tk0 : tk1) - t !== k) begin
        bad++; $display("FAIL rand_taken[%0d] ch%0d: got %0d required %0d", it, ch, (ch == 0 ? tk0 : tk1) - t, k);
      end
    end
  endtask

`ifdef JTAG_DR_TDO_STATUS_EN
  task automatic test_status();
    logic [63:0] v;
    load(1, 32'h0000_0001);
    m_full[1] = 0;
    read(1, SW, v);
    total++;
    if (v !== 64'd3) begin bad++; $display("FAIL status_read: got %h required 3", v); end
  endtask
`endif

  initial begin
    m_full[0] = 0; m_full[1] = 0;
    m_mb[0] = '0; m_mb[1] = '0;
    #1;
    test_reset();
    test_basic();
    test_empty();
    test_collision();
    test_tap_reset();
    test_random();
`ifdef JTAG_DR_TDO_STATUS_EN
    test_status();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtag_dr_tdo.md
Name: jtag_dr_tdo

Overview:
- Return path of the JTAGG user-DR debug link: the TDO-side transmitter for the ER1 (IR 0x32) and ER2 (IR 0x38) data registers.
- The SoC loads 32-bit words into two one-deep mailboxes. The host reads them by scanning the matching DR, and the block drives JTDO1/JTDO2 of the JTAGG primitive.
- Sits in the top level next to the TDI-side DR receiver, in the clk48m domain. It oversamples JTCK the same way the receiver does.

Parameters:
- WIDTH, 32, mailbox/data word width in bits.
- SYNC_STAGES, 4, depth of the JTCK/control oversampling shift line (minimum 3).

Ports:
- clk  in  1  system clock (clk48m)
- rstn  in  1  asynchronous active-low reset
- jtck  in  1  JTCK from JTAGG (asynchronous)
- jshift  in  1  JSHIFT from JTAGG
- jce1  in  1  JCE1 (ER1 selected, Capture/Shift-DR)
- jce2  in  1  JCE2 (ER2 selected, Capture/Shift-DR)
- jrstn  in  1  JRSTN from JTAGG, TAP reset, active low
- tx_data0  in  WIDTH  word for ER1 mailbox
- tx_load0  in  1  one-cycle strobe, load tx_data0
- tx_full0  out  1  ER1 mailbox holds an unread word
- tx_taken0  out  1  one-cycle pulse: ER1 word captured by host
- tx_data1, tx_load1, tx_full1, tx_taken1: same as above, for ER2
- jtdo1  out  1  to JTAGG JTDO1
- jtdo2  out  1  to JTAGG JTDO2

Behaviour:
- Reset (rstn=0, asynchronous):
  - all outputs 0;
  - mailboxes empty;
  - shift registers 0;
  - sync line 0.
- Oversampling:
  - jtck, jshift, jce1 and jce2 each shift through SYNC_STAGES flops every clk.
  - rise = stage[N-1]==0 && stage[N-2]==1.
  - fall = stage[N-1]==1 && stage[N-2]==0.
  - jshift/jce values used at an edge are the ones taken from stage[N-2].
- TAP reset: while jrstn==0 (sampled each clk):
  - shift registers, jtdo1 and jtdo2 are held at 0;
  - edges are ignored;
  - mailboxes and tx_full are untouched.
- Per-channel k on rise, with jce_k=1 and jshift=0 (Capture-DR):
  - shreg_k <= mailbox_k if full_k, else all-zero;
  - if full_k: full_k<=0 and tx_taken_k=1 for exactly one clk.
- Per-channel k on rise, with jce_k=1 and jshift=1 (Shift-DR):
  - shreg_k <= {1'b0, shreg_k[top:1]} (LSB first, zero fill);
  - after the full length has been shifted out, the register reads all zeros.
- On fall: jtdo_k <= shreg_k[0], updating TDO on the falling TCK edge per IEEE 1149.1.
  - A channel whose jce is 0 keeps its shreg and jtdo unchanged.
- Mailbox load: tx_load_k loads tx_data_k and sets full_k on the next clk edge (1-cycle latency).
  - Load while full: the data is overwritten, full stays 1, and no taken pulse is generated.
- Simultaneous load and capture in the same clk:
  - capture uses the pre-load contents and state;
  - if it was full: taken pulses, and the new word is stored with full=1;
  - if it was empty: zeros are captured, and the new word is stored with full=1.
- jce1 and jce2 are never both 1. If they are, channel 0 acts and channel 1 ignores the edge.
- Only one edge type can occur per clk, by construction of the sync line.

Optional Feature:
- Macro: JTAG_DR_TDO_STATUS_EN.
- When defined:
  - each shift register is WIDTH+1 bits;
  - capture loads {mailbox_k, full_k}, so the host sees a valid flag first (bit 0), then data LSB-first;
  - an empty capture yields all zeros, including flag=0.
- When undefined:
  - shift registers are WIDTH bits;
  - the host distinguishes an empty mailbox only by an all-zero read.

Test Plan:
- Reset/idle: rstn pulsed low mid-shift -> jtdo1=jtdo2=0, tx_full*=0, no taken pulses, sync line flushed.
- Basic read ER1: load tx_data0=0xDEADBEEF; JTCK at 1 MHz; Capture then 32 Shift-DR cycles with jce1=1 -> bits on jtdo1 sampled at TCK rise = EF,BE,AD,DE LSB-first; tx_full0 1→0 and tx_taken0 a single 1-clk pulse at the capture rise; jtdo2 stays 0.
- Empty read ER2: capture/shift 32 bits with jce2=1, tx_full1=0 -> jtdo2 all 0, no tx_taken1. With JTAG_DR_TDO_STATUS_EN, 33 zero bits.
- Collision: assert tx_load0 (0x12345678) in the same clk as the capture rise, old word 0x0000AAAA full -> host reads 0x0000AAAA, tx_taken0 pulses, tx_full0=1 afterwards holding 0x12345678.
- TAP reset mid-shift: pull jrstn low after 10 shifted bits of 0xCAFEF00D -> jtdo1 = 0 and the shift register clears; tx_full0 is unchanged (already 0 after capture). A new load followed by a read returns the new word intact.
- Status mode (JTAG_DR_TDO_STATUS_EN): load 0x00000001 on ER2 -> first jtdo2 bit 1 (flag), then 1, then 31 zeros.
